// File: rtl/hazard_scoreboard.sv
// Load/RAW hazard scoreboard: tracks DEPTH in-flight destinations behind ID and raises a same-cycle stall.
// Optional stall counter is built when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_EN,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1_ID,
    input  logic [REG_ADDR_W-1:0] src2_ID,
    input  logic                  is_imm,
    input  logic                  ST_or_BNE,
    input  logic                  is_branch_ID,
    input  logic [REG_ADDR_W-1:0] dest_ID,
    input  logic                  WB_EN_ID,
    input  logic                  MEM_R_EN_ID,
    input  logic                  flush,
    output logic                  hazard_detected
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DEPTH-1:0]                 wb_en_q, wb_en_d;
    logic [DEPTH-1:0]                 mem_r_q, mem_r_d;
    logic [DEPTH-1:0]                 shift_valid_s;
    logic [DEPTH-1:0]                 match_s;
    logic                             src2_used_s;
    logic                             any_match_s;
    logic                             hazard_s;

    // Per-entry RAW match against the instruction sitting in ID.
    always_comb begin
        src2_used_s = ~is_imm | ST_or_BNE;
        match_s     = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = valid_q[k] & wb_en_q[k] &
                         (dest_q[k] != {REG_ADDR_W{1'b0}}) &
                         ((src1_ID == dest_q[k]) |
                          (src2_used_s & (src2_ID == dest_q[k])));
        end
        any_match_s = |match_s;
    end

    // With forwarding only branches (resolved in ID) and load-use in EXE must wait.
    always_comb begin
        if (forward_EN) begin
            hazard_s = id_valid & ((is_branch_ID & any_match_s) |
                                   (match_s[0] & mem_r_q[0]));
        end else begin
            hazard_s = id_valid & any_match_s;
        end
    end

    assign hazard_detected = hazard_s;

    // Advance the tracking pipe; a stall injects a bubble and flush kills every entry.
    always_comb begin
        shift_valid_s = valid_q;
        dest_d        = dest_q;
        wb_en_d       = wb_en_q;
        mem_r_d       = mem_r_q;
        for (int k = DEPTH - 1; k > 0; k--) begin
            shift_valid_s[k] = valid_q[k-1];
            dest_d[k]        = dest_q[k-1];
            wb_en_d[k]       = wb_en_q[k-1];
            mem_r_d[k]       = mem_r_q[k-1];
        end
        shift_valid_s[0] = id_valid & ~hazard_s;
        dest_d[0]        = dest_ID;
        wb_en_d[0]       = WB_EN_ID;
        mem_r_d[0]       = MEM_R_EN_ID;
        valid_d          = flush ? {DEPTH{1'b0}} : shift_valid_s;
    end

    // Tracking entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {DEPTH{1'b0}};
            dest_q  <= '0;
            wb_en_q <= {DEPTH{1'b0}};
            mem_r_q <= {DEPTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            dest_q  <= dest_d;
            wb_en_q <= wb_en_d;
            mem_r_q <= mem_r_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        if (hazard_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=2, CNT_W=2); counter checks built with HAZARD_STALL_CNT_EN.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          forward_EN;
    logic          id_valid;
    logic [AW-1:0] src1_ID, src2_ID, dest_ID;
    logic          is_imm, ST_or_BNE, is_branch_ID;
    logic          WB_EN_ID, MEM_R_EN_ID;
    logic          flush;
    logic          hazard_detected;
`ifdef HAZARD_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.REG_ADDR_W(AW), .DEPTH(2), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .forward_EN     (forward_EN),
        .id_valid       (id_valid),
        .src1_ID        (src1_ID),
        .src2_ID        (src2_ID),
        .is_imm         (is_imm),
        .ST_or_BNE      (ST_or_BNE),
        .is_branch_ID   (is_branch_ID),
        .dest_ID        (dest_ID),
        .WB_EN_ID       (WB_EN_ID),
        .MEM_R_EN_ID    (MEM_R_EN_ID),
        .flush          (flush),
        .hazard_detected(hazard_detected)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input int s1, input int s2, input logic imm,
                          input logic stb, input logic br, input int d,
                          input logic wb, input logic mr);
        id_valid     = v;
        src1_ID      = AW'(s1);
        src2_ID      = AW'(s2);
        is_imm       = imm;
        ST_or_BNE    = stb;
        is_branch_ID = br;
        dest_ID      = AW'(d);
        WB_EN_ID     = wb;
        MEM_R_EN_ID  = mr;
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drain();
        set_id(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        forward_EN = 1'b0;
        set_id(1'b1, 3, 3, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_hazard", int'(hazard_detected), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("reset_cnt", int'(stall_cnt), 0);
`endif
        drain();

        // No forwarding: ADD r3 then consumer of r3 stalls DEPTH cycles
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        check("add_r3_issue", int'(hazard_detected), 0);
        step();
        set_id(1'b1, 3, 1, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0);
        check("nofwd_stall1", int'(hazard_detected), 1);
        step();
        check("nofwd_stall2", int'(hazard_detected), 1);
        step();
        check("nofwd_release", int'(hazard_detected), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("nofwd_cnt", int'(stall_cnt), 2);
`endif
        step();
        drain();

        // Forwarding: load-use stalls exactly one cycle
        forward_EN = 1'b1;
        set_id(1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b1);
        check("lw_r4_issue", int'(hazard_detected), 0);
        step();
        set_id(1'b1, 7, 4, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        check("loaduse_stall", int'(hazard_detected), 1);
        step();
        check("loaduse_release", int'(hazard_detected), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("loaduse_cnt", int'(stall_cnt), 3);
`endif
        step();
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        check("add_r4_issue", int'(hazard_detected), 0);
        step();
        set_id(1'b1, 7, 4, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        check("add_fwd_nostall", int'(hazard_detected), 0);
        step();
        drain();

        // src2 only counts when used; id_valid=0 masks everything
        set_id(1'b1, 1, 2, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b1);
        step();
        set_id(1'b1, 7, 9, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        check("src2_unused", int'(hazard_detected), 0);
        set_id(1'b1, 7, 9, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("src2_store", int'(hazard_detected), 1);
        set_id(1'b0, 7, 9, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("id_invalid", int'(hazard_detected), 0);
        step();
        drain();

        // Forwarding: branch on r5 waits for both stages; r0 never matches
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("bne_stall1", int'(hazard_detected), 1);
        step();
        check("bne_stall2", int'(hazard_detected), 1);
        step();
        check("bne_release", int'(hazard_detected), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("cnt_saturated", int'(stall_cnt), 3);
`endif
        step();
        drain();
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        step();
        set_id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        check("bne_r0", int'(hazard_detected), 0);
        step();
        drain();

        // Flush during a stall kills tracked entries
        forward_EN = 1'b0;
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0);
        step();
        set_id(1'b1, 10, 1, 1'b0, 1'b0, 1'b0, 11, 1'b1, 1'b0);
        check("pre_flush_stall", int'(hazard_detected), 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("post_flush", int'(hazard_detected), 0);
        step();
        drain();

        // Reset during a stall aborts it and clears the counter
        set_id(1'b1, 1, 2, 1'b0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
        step();
        set_id(1'b1, 12, 1, 1'b0, 1'b0, 1'b0, 13, 1'b1, 1'b0);
        check("pre_rst_stall", int'(hazard_detected), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_hazard", int'(hazard_detected), 0);
`ifdef HAZARD_STALL_CNT_EN
        check("post_rst_cnt", int'(stall_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
